// File: rtl/cpu_clock_ctrl_if.sv
// Signal bundle between the board top and the cpu clock sequencer.
// The master side is the sequencer (takes buttons, drives the cpu clock);
// the slave side is the board/debug logic.
// Optional macro CLKCTRL_BREAKPOINT_EN adds the breakpoint compare inputs.
interface cpu_clock_ctrl_if #(
   parameter int unsigned DIV_WIDTH = 25,
   parameter int unsigned CNT_WIDTH = 16
);
   logic                 btn_step;
   logic                 btn_run;
   logic [DIV_WIDTH-1:0] div_sel;
   logic                 halt_req;
`ifdef CLKCTRL_BREAKPOINT_EN
   logic [15:0]          pc_in;
   logic [15:0]          bp_addr;
   logic                 bp_valid;
`endif
   logic                 cpu_clk;
   logic                 cpu_tick;
   logic                 running;
   logic [CNT_WIDTH-1:0] cycle_count;

   modport master (
      input  btn_step,
      input  btn_run,
      input  div_sel,
      input  halt_req,
`ifdef CLKCTRL_BREAKPOINT_EN
      input  pc_in,
      input  bp_addr,
      input  bp_valid,
`endif
      output cpu_clk,
      output cpu_tick,
      output running,
      output cycle_count
   );

   modport slave (
      output btn_step,
      output btn_run,
      output div_sel,
      output halt_req,
`ifdef CLKCTRL_BREAKPOINT_EN
      output pc_in,
      output bp_addr,
      output bp_valid,
`endif
      input  cpu_clk,
      input  cpu_tick,
      input  running,
      input  cycle_count
   );
endinterface

// File: rtl/cpu_clock_ctrl.sv
// cpu clock sequencer: debounces the step and run buttons and generates the
// cpu clock, either one manual pulse per step press or free-running with a
// programmable half-period. Counts cpu clock rising edges for display.
// Optional macro CLKCTRL_BREAKPOINT_EN enables a pc breakpoint that halts RUN
// at the end of a low phase when pc_in matches bp_addr.
module cpu_clock_ctrl #(
   parameter int unsigned DEBOUNCE_CYCLES = 250000,
   parameter int unsigned DIV_WIDTH       = 25,
   parameter int unsigned CNT_WIDTH       = 16
) (
   input logic              clk,
   input logic              reset,
   cpu_clock_ctrl_if.master bus
);

   localparam int unsigned DbW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [2:0] {
      StHalt,
      StStepHi,
      StStepLo,
      StRunLo,
      StRunHi,
      StStopHi
   } state_e;

   // Index 0 is the step button, index 1 the run button.
   logic [1:0]     btn_raw;
   logic [1:0]     sync_a;
   logic [1:0]     sync_b;
   logic [1:0]     db_level;
   logic [1:0]     press;
   logic [DbW-1:0] db_cnt [2];

   state_e               state_q;
   logic [DIV_WIDTH-1:0] phase_cnt_q;
   logic [DIV_WIDTH-1:0] phase_load;
   logic                 stop_pend_q;
   logic                 cpu_clk_q;
   logic                 cpu_tick_q;
   logic                 running_q;
   logic [CNT_WIDTH-1:0] cycle_cnt_q;

   logic step_press;
   logic run_press;
   logic stop_now;
   logic phase_end;
   logic bp_hit;

   assign btn_raw    = {bus.btn_run, bus.btn_step};
   assign step_press = press[0];
   assign run_press  = press[1];
   assign stop_now   = run_press | bus.halt_req;
   assign phase_end  = (phase_cnt_q == '0);
   // Phase counter counts down from H-1, with H = max(div_sel, 1).
   assign phase_load = (bus.div_sel == '0) ? '0 : bus.div_sel - DIV_WIDTH'(1);

   // Synchronize each button, accept a new level only after it has been stable
   // for DEBOUNCE_CYCLES cycles, and pulse on an accepted 0->1 transition.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_a    <= '0;
         sync_b    <= '0;
         db_level  <= '0;
         press     <= '0;
         db_cnt[0] <= '0;
         db_cnt[1] <= '0;
      end else begin
         sync_a <= btn_raw;
         sync_b <= sync_a;
         for (int i = 0; i < 2; i++) begin
            press[i] <= 1'b0;
            if (sync_b[i] == db_level[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DbLast) begin
               db_cnt[i]   <= '0;
               db_level[i] <= sync_b[i];
               press[i]    <= sync_b[i];
            end else begin
               db_cnt[i] <= db_cnt[i] + DbW'(1);
            end
         end
      end
   end

`ifdef CLKCTRL_BREAKPOINT_EN
   logic bp_armed_q;

   assign bp_hit = bp_armed_q & bus.bp_valid & (bus.pc_in == bus.bp_addr);

   // Disarm on HALT so a run started at the breakpoint retires one cycle first.
   always_ff @(posedge clk) begin
      if (reset) begin
         bp_armed_q <= 1'b0;
      end else if (state_q == StHalt) begin
         bp_armed_q <= 1'b0;
      end else if (state_q == StRunHi) begin
         bp_armed_q <= 1'b1;
      end
   end
`else
   assign bp_hit = 1'b0;
`endif

   // Clock sequencer FSM; all outputs are registered here.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= StHalt;
         phase_cnt_q <= '0;
         stop_pend_q <= 1'b0;
         cpu_clk_q   <= 1'b0;
         cpu_tick_q  <= 1'b0;
         running_q   <= 1'b0;
         cycle_cnt_q <= '0;
      end else begin
         cpu_tick_q <= 1'b0;
         unique case (state_q)
            StHalt: begin
               stop_pend_q <= 1'b0;
               // Run wins a simultaneous press unless the cpu is requesting halt.
               if (run_press && !bus.halt_req) begin
                  state_q     <= StRunLo;
                  phase_cnt_q <= phase_load;
                  running_q   <= 1'b1;
               end else if (step_press) begin
                  state_q     <= StStepHi;
                  phase_cnt_q <= phase_load;
                  cpu_clk_q   <= 1'b1;
                  cpu_tick_q  <= 1'b1;
                  cycle_cnt_q <= cycle_cnt_q + CNT_WIDTH'(1);
               end
            end
            StStepHi: begin
               if (phase_end) begin
                  state_q     <= StStepLo;
                  phase_cnt_q <= phase_load;
                  cpu_clk_q   <= 1'b0;
               end else begin
                  phase_cnt_q <= phase_cnt_q - DIV_WIDTH'(1);
               end
            end
            StStepLo: begin
               if (phase_end) begin
                  state_q <= StHalt;
               end else begin
                  phase_cnt_q <= phase_cnt_q - DIV_WIDTH'(1);
               end
            end
            StRunLo: begin
               if (phase_end) begin
                  if (stop_pend_q || stop_now || bp_hit) begin
                     state_q     <= StHalt;
                     running_q   <= 1'b0;
                     stop_pend_q <= 1'b0;
                  end else begin
                     state_q     <= StRunHi;
                     phase_cnt_q <= phase_load;
                     cpu_clk_q   <= 1'b1;
                     cpu_tick_q  <= 1'b1;
                     cycle_cnt_q <= cycle_cnt_q + CNT_WIDTH'(1);
                  end
               end else begin
                  phase_cnt_q <= phase_cnt_q - DIV_WIDTH'(1);
                  stop_pend_q <= stop_pend_q | stop_now;
               end
            end
            StRunHi: begin
               if (phase_end) begin
                  cpu_clk_q <= 1'b0;
                  if (stop_now) begin
                     state_q   <= StHalt;
                     running_q <= 1'b0;
                  end else begin
                     state_q     <= StRunLo;
                     phase_cnt_q <= phase_load;
                  end
               end else begin
                  phase_cnt_q <= phase_cnt_q - DIV_WIDTH'(1);
                  // The high phase is never truncated; finish it out of RUN.
                  if (stop_now) begin
                     state_q   <= StStopHi;
                     running_q <= 1'b0;
                  end
               end
            end
            StStopHi: begin
               if (phase_end) begin
                  state_q   <= StHalt;
                  cpu_clk_q <= 1'b0;
               end else begin
                  phase_cnt_q <= phase_cnt_q - DIV_WIDTH'(1);
               end
            end
            default: begin
               state_q   <= StHalt;
               cpu_clk_q <= 1'b0;
               running_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.cpu_clk     = cpu_clk_q;
   assign bus.cpu_tick    = cpu_tick_q;
   assign bus.running     = running_q;
   assign bus.cycle_count = cycle_cnt_q;

endmodule
